// File: rtl/pipe_adder_pkg.sv
// Shared constants, configuration helpers and the inter-stage payload type
// for the segmented pipelined adder.
package pipe_adder_pkg;

  // Widest operand the stage payload can carry.
  localparam int unsigned MAX_WIDTH = 64;

  // Number of add stages for a given operand width and segment width.
  function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  // Width must split evenly into segments and fit the payload.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned seg);
    return (seg != 0) && (width >= seg) && ((width % seg) == 0) && (width <= MAX_WIDTH);
  endfunction

  // Stage payload: the sum built so far, the carry into the next segment, the
  // operand slices not yet consumed (low segment next), and the subtract flag.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] acc_sum;
    logic                 carry;
    logic [MAX_WIDTH-1:0] hi_a;
    logic [MAX_WIDTH-1:0] hi_b;
    logic                 sub;
  } stage_pay_t;

endpackage

// File: rtl/pipe_adder_hs_if.sv
// Operand/result handshake bundle for pipe_adder_hs.
// PIPE_ADDER_SUB_EN adds the subtract-select signal.
interface pipe_adder_hs_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  // Environment side: produces operands, consumes results.
  modport master (
    output in_valid, a, b, ci,
`ifdef PIPE_ADDER_SUB_EN
    sub,
`endif
    out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  // Adder side: accepts operands, presents results.
  modport slave (
    input  in_valid, a, b, ci,
`ifdef PIPE_ADDER_SUB_EN
    sub,
`endif
    out_ready,
    output in_ready, out_valid, s, co, ovf
  );

endinterface

// File: rtl/pipe_adder_seg.sv
// One SEG-bit add stage: adds the low operand slices plus incoming carry,
// deposits the segment sum at its position, and shifts the remaining slices.
module pipe_adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int unsigned SEG   = 8,
  parameter int unsigned STAGE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       v_in,
  input  stage_pay_t pay_in,
  output logic       v_out,
  output stage_pay_t pay_out,
  output logic       ovf
);

  localparam int unsigned SW = SEG + 1;

  logic [SEG-1:0] a_seg;
  logic [SEG-1:0] b_seg;
  logic [SEG-1:0] sum;
  logic           c_out;
  logic           ovf_nxt;
  stage_pay_t     pay_nxt;

  // Segment add; overflow uses carry into the segment MSB vs carry out.
  always_comb begin
    a_seg          = pay_in.hi_a[SEG-1:0];
    b_seg          = pay_in.hi_b[SEG-1:0] ^ {SEG{pay_in.sub}};
    {c_out, sum}   = SW'(a_seg) + SW'(b_seg) + SW'(pay_in.carry);
    ovf_nxt        = a_seg[SEG-1] ^ b_seg[SEG-1] ^ sum[SEG-1] ^ c_out;
    pay_nxt        = pay_in;
    pay_nxt.acc_sum[STAGE*SEG +: SEG] = sum;
    pay_nxt.carry  = c_out;
    pay_nxt.hi_a   = pay_in.hi_a >> SEG;
    pay_nxt.hi_b   = pay_in.hi_b >> SEG;
  end

  // Stage register: loads on enable, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_out   <= 1'b0;
      pay_out <= '0;
      ovf     <= 1'b0;
    end else if (en) begin
      v_out   <= v_in;
      pay_out <= pay_nxt;
      ovf     <= ovf_nxt;
    end
  end

endmodule

// File: rtl/pipe_adder_hs.sv
// Carry-segmented pipelined adder with valid/ready flow control.
// Stage 0 captures operands; NSEG segment stages follow; results come
// straight from the last stage registers. in_ready is combinational from
// out_ready through the per-stage enable chain, so bubbles collapse.
// Optional: define PIPE_ADDER_SUB_EN for a - b - ci via the sub signal.
module pipe_adder_hs
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input logic           clk,
  input logic           rst,
  pipe_adder_hs_if.slave bus
);

  localparam int unsigned NSEG   = calc_nseg(WIDTH, SEG);
  localparam bit          CFG_OK = cfg_ok(WIDTH, SEG);

  if (!CFG_OK) begin : g_cfg_err
    $error("pipe_adder_hs: WIDTH must be a nonzero multiple of SEG and at most MAX_WIDTH");
  end

  logic [NSEG+1:0] en;
  logic [NSEG:0]   v;
  stage_pay_t      pay [0:NSEG];
  logic            ovf_st [1:NSEG];
  logic            v0;
  stage_pay_t      pay0;
  logic            sub_in;

`ifdef PIPE_ADDER_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Advance chain: a stage loads if empty or if the stage after it moves.
  always_comb begin
    en           = '0;
    en[NSEG+1]   = bus.out_ready;
    for (int k = NSEG; k >= 0; k--) begin
      en[k] = ~v[k] | en[k+1];
    end
  end

  // Stage 0: capture operands, subtract flag and effective carry-in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0   <= 1'b0;
      pay0 <= '0;
    end else if (en[0]) begin
      v0           <= bus.in_valid;
      pay0.acc_sum <= '0;
      pay0.carry   <= bus.ci ^ sub_in;
      pay0.hi_a    <= MAX_WIDTH'(bus.a);
      pay0.hi_b    <= MAX_WIDTH'(bus.b);
      pay0.sub     <= sub_in;
    end
  end

  assign v[0]   = v0;
  assign pay[0] = pay0;

  for (genvar k = 1; k <= NSEG; k++) begin : g_seg
    pipe_adder_seg #(
      .SEG   (SEG),
      .STAGE (k - 1)
    ) u_seg (
      .clk     (clk),
      .rst     (rst),
      .en      (en[k]),
      .v_in    (v[k-1]),
      .pay_in  (pay[k-1]),
      .v_out   (v[k]),
      .pay_out (pay[k]),
      .ovf     (ovf_st[k])
    );
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v[NSEG];
  assign bus.s         = pay[NSEG].acc_sum[WIDTH-1:0];
  assign bus.co        = pay[NSEG].carry;
  assign bus.ovf       = ovf_st[NSEG];

endmodule

// File: tb/tb_pipe_adder_hs.sv
// Bench for pipe_adder_hs: directed table, stall, reset and random streaming
// against an arithmetic reference model. Also covers an NSEG=1 instance.
module tb_pipe_adder_hs;

  localparam int unsigned W   = 32;
  localparam int unsigned SG  = 8;
  localparam int          LAT = W / SG + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_adder_hs_if #(.WIDTH(W))  bus ();
  pipe_adder_hs_if #(.WIDTH(16)) bus1 ();

  pipe_adder_hs #(.WIDTH(W),  .SEG(SG)) dut  (.clk(clk), .rst(rst), .bus(bus));
  pipe_adder_hs #(.WIDTH(16), .SEG(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the operands, overflow from signed range.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    res_t r;
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned uc = 64'(ci);
    longint unsigned t;
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint res;
    if (sb) begin
      r.s  = 32'(ua - ub - uc);
      r.co = (ua >= ub + uc);
      res  = sa - sbv - longint'(uc);
    end else begin
      t    = ua + ub + uc;
      r.s  = 32'(t);
      r.co = t[32];
      res  = sa + sbv + longint'(uc);
    end
    r.ovf = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    return r;
  endfunction

  function automatic logic rand_sub();
`ifdef PIPE_ADDER_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb, input logic ordy);
    bus.in_valid  = iv;
    bus.a         = a;
    bus.b         = b;
    bus.ci        = ci;
`ifdef PIPE_ADDER_SUB_EN
    bus.sub       = sb;
`else
    if (sb) bus.ci = ci;
`endif
    bus.out_ready = ordy;
  endtask

  // One clock: drive at negedge, record transfers that the next posedge performs.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb, input logic ordy,
                       output logic fin, output logic fout);
    res_t r;
    @(negedge clk);
    drive(iv, a, b, ci, sb, ordy);
    #1;
    cyc++;
    fin  = iv && bus.in_ready;
    fout = bus.out_valid && ordy;
    if (fin) exp_q.push_back(model(a, b, ci, sb));
    if (fout) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=%0h expected=none", bus.s);
      end else begin
        r = exp_q.pop_front();
        chk("stream_s",   bus.s,   r.s);
        chk("stream_co",  bus.co,  r.co);
        chk("stream_ovf", bus.ovf, r.ovf);
      end
    end
  endtask

  // Single transaction into an idle pipe: checks latency, result, no duplicate.
  task automatic one_shot(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    drive(1'b1, v.a, v.b, v.ci, v.sb, 1'b1);
    #1;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    drive(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_s"},   bus.s,   v.s);
    chk({tag, "_co"},  bus.co,  v.co);
    chk({tag, "_ovf"}, bus.ovf, v.ovf);
    @(negedge clk);
    chk({tag, "_no_dup"}, bus.out_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic fin, fout;
    int   nin, nout, first_in, first_out, last_out, n;
    logic [31:0] held_s;
    logic held;

    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0; bus1.out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    bus1.sub = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_s",   bus.s,   0);
    chk("rst_co",  bus.co,  0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Directed table
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0});
`ifdef PIPE_ADDER_SUB_EN
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
`endif
    foreach (vecs[i]) one_shot(vecs[i], $sformatf("vec%0d", i));

    // NSEG=1 instance: two-cycle latency
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus1.a = (t == 0) ? 16'hFFFF : 16'h7FFF;
      bus1.b = 16'h0001;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      n = 1;
      while (!bus1.out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("nseg1_latency", n, 2);
      chk("nseg1_s",   bus1.s,   (t == 0) ? 16'h0000 : 16'h8000);
      chk("nseg1_co",  bus1.co,  (t == 0) ? 1'b1 : 1'b0);
      chk("nseg1_ovf", bus1.ovf, (t == 0) ? 1'b0 : 1'b1);
    end

    // Back-to-back stream of 20
    nin = 0; nout = 0; first_in = -1; first_out = -1; last_out = -1;
    for (int i = 0; i < 20 + 20; i++) begin
      if (i < 20) cycle(1'b1, $urandom, $urandom, 1'($urandom), rand_sub(), 1'b1, fin, fout);
      else        cycle(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1, fin, fout);
      if (fin) begin nin++; if (first_in < 0) first_in = cyc; end
      if (fout) begin nout++; if (first_out < 0) first_out = cyc; last_out = cyc; end
    end
    chk("stream_accepts", nin, 20);
    chk("stream_outputs", nout, 20);
    chk("stream_fill", first_out - first_in, LAT);
    chk("stream_rate", last_out - first_out, 19);

    // Stall: out_ready low for 10 cycles with in_valid high
    nin = 0; held = 1'b0; held_s = '0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, $urandom, $urandom, 1'($urandom), rand_sub(), 1'b0, fin, fout);
      if (fin) nin++;
      if (bus.out_valid) begin
        if (held) chk("stall_hold_s", bus.s, held_s);
        held = 1'b1;
        held_s = bus.s;
      end
    end
    chk("stall_accepts", nin, 5);
    chk("stall_in_ready", bus.in_ready, 0);
    nout = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1, fin, fout);
      if (fout) nout++;
    end
    chk("stall_drained", nout, 5);

    // Reset mid-operation with three results in flight
    cycle(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0, fin, fout);
    cycle(1'b1, 32'h01010101, 32'h10101010, 1'b1, 1'b0, 1'b0, fin, fout);
    cycle(1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, fin, fout);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, fin, fout);
      n++;
    end
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_s", bus.s, 32'h33333333);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_s",   bus.s,   0);
    chk("midrst_co",  bus.co,  0);
    chk("midrst_ovf", bus.ovf, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    one_shot(vecs[2], "post_rst");

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), $urandom, $urandom, 1'($urandom), rand_sub(),
            1'($urandom_range(0, 9) < 6), fin, fout);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, fin, fout);
    end
    chk("random_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
